// File: rtl/icache_assoc_if.sv
// icache_assoc_if: fetch lookup and line-fill signals between a fetch unit / fill path and icache_assoc.
interface icache_assoc_if #(
   parameter int PA = 22,
   parameter int RV = 16,
   parameter int LINE_LENGTH = 4,
   parameter int FW = 4
);
   localparam int OFF = $clog2(LINE_LENGTH);
   logic req;
   logic [PA-1:1] paddr;
   logic flush_all;
   logic hit;
   logic [RV-1:0] rdata;
   logic busy;
   logic fill_req;
   logic [PA-OFF-1:0] fill_addr;
   logic fill_valid;
   logic [FW-1:0] fill_data;
   modport master (
      output req, paddr, flush_all, fill_valid, fill_data,
      input hit, rdata, busy, fill_req, fill_addr
   );
   modport slave (
      input req, paddr, flush_all, fill_valid, fill_data,
      output hit, rdata, busy, fill_req, fill_addr
   );
endinterface

// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with LRU replacement and its own line-fill FSM.
// Defining ICACHE_PERF_EN adds saturating hit_cnt/miss_cnt outputs.
module icache_assoc #(
   parameter int PA = 22,
   parameter int RV = 16,
   parameter int LINE_LENGTH = 4,
   parameter int NSETS = 4,
   parameter int WAYS = 2,
   parameter int FW = 4
) (
   input logic clk,
   input logic reset,
   icache_assoc_if.slave bus
`ifdef ICACHE_PERF_EN
   ,
   output logic [15:0] hit_cnt,
   output logic [15:0] miss_cnt
);
`else
);
`endif
   localparam int OFF = $clog2(LINE_LENGTH);
   localparam int IW = $clog2(NSETS);
   localparam int TW = PA - OFF - IW;
   localparam int LB = LINE_LENGTH * 8;
   localparam int BEATS = LB / FW;
   localparam int CW = $clog2(BEATS) + 1;
   localparam int BO = $clog2(RV / 8);
   typedef enum logic {IDLE, FILL} state_t;
   state_t state, state_nx;
   logic [PA-1:0] addr;
   logic [IW-1:0] idx;
   logic [TW-1:0] tag;
   logic [OFF-1:0] boff;
   logic valid [WAYS][NSETS];
   logic [TW-1:0] tags [WAYS][NSETS];
   logic [LB-1:0] data [WAYS][NSETS];
   logic [NSETS-1:0] lru;
   logic [CW-1:0] cnt;
   logic abort;
   logic victim, victim_nx;
   logic [PA-OFF-1:0] fill_line;
   logic [IW-1:0] fill_idx;
   logic any_hit, hit_way;
   logic start, last_beat;
   assign addr = {bus.paddr, 1'b0};
   assign idx = addr[OFF+IW-1:OFF];
   assign tag = addr[PA-1:OFF+IW];
   assign boff = (addr[OFF-1:0] >> BO) << BO;
   assign fill_idx = fill_line[IW-1:0];
   // The victim's valid bit is cleared when the fill starts, so it can never hit mid-fill.
   always_comb begin
      any_hit = 1'b0;
      hit_way = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (valid[w][idx] && tags[w][idx] == tag) begin
            any_hit = 1'b1;
            hit_way = 1'(w);
         end
   end
   always_comb begin
      victim_nx = (WAYS == 2) ? lru[idx] : 1'b0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (!valid[w][idx]) victim_nx = 1'(w);
   end
   assign bus.hit = bus.req && any_hit;
   assign bus.rdata = data[hit_way][idx][{boff, 3'b000} +: RV];
   assign bus.busy = state == FILL;
   assign bus.fill_req = state == FILL;
   assign bus.fill_addr = fill_line;
   assign start = state == IDLE && bus.req && !any_hit && !bus.flush_all;
   assign last_beat = state == FILL && bus.fill_valid && cnt == CW'(BEATS - 1);
   always_comb begin
      state_nx = start ? FILL : last_beat ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= state_nx;
   end
   // Later assignments win: a completing fill overrides a same-set hit, and flush overrides both.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
         abort <= 1'b0;
         victim <= 1'b0;
         fill_line <= '0;
         lru <= '0;
         for (int w = 0; w < WAYS; w++)
            for (int s = 0; s < NSETS; s++) valid[w][s] <= 1'b0;
      end else begin
         if (bus.hit && WAYS == 2) lru[idx] <= ~hit_way;
         if (start) begin
            fill_line <= addr[PA-1:OFF];
            victim <= victim_nx;
            valid[victim_nx][idx] <= 1'b0;
            cnt <= '0;
            abort <= 1'b0;
         end
         if (state == FILL && bus.fill_valid) cnt <= cnt + 1'b1;
         if (state == FILL && bus.flush_all) abort <= 1'b1;
         if (last_beat) begin
            valid[victim][fill_idx] <= !abort && !bus.flush_all;
            if (WAYS == 2) lru[fill_idx] <= ~victim;
         end
         if (bus.flush_all) begin
            lru <= '0;
            for (int w = 0; w < WAYS; w++)
               for (int s = 0; s < NSETS; s++) valid[w][s] <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset && state == FILL && bus.fill_valid) data[victim][fill_idx][int'(cnt) * FW +: FW] <= bus.fill_data;
      if (reset && last_beat) tags[victim][fill_idx] <= fill_line[PA-OFF-1:IW];
   end
`ifdef ICACHE_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_cnt <= '0;
         miss_cnt <= '0;
      end else begin
         if (bus.hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
         if (start && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed scenarios plus random traffic against a line-level reference model.
module tb_icache_assoc;
   localparam int PA = 22, RV = 16, LL = 4, NS = 4, WAYS = 2, FW = 4, BEATS = 8;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   icache_assoc_if #(.PA(PA), .RV(RV), .LINE_LENGTH(LL), .FW(FW)) bus ();
`ifdef ICACHE_PERF_EN
   logic [15:0] hit_cnt, miss_cnt;
   icache_assoc #(.PA(PA), .RV(RV), .LINE_LENGTH(LL), .NSETS(NS), .WAYS(WAYS), .FW(FW)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
`else
   icache_assoc #(.PA(PA), .RV(RV), .LINE_LENGTH(LL), .NSETS(NS), .WAYS(WAYS), .FW(FW)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));
`endif
   int nvec = 0, nerr = 0;
   bit mv [WAYS][NS];
   logic [17:0] mt [WAYS][NS];
   logic [31:0] ml [WAYS][NS];
   bit mlru [NS];
   bit mfill, mabort;
   logic [19:0] mfa;
   int mvic;
   logic [3:0] mbeats [$];
   int mhit_n, mmiss_n;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_flush();
      for (int s = 0; s < NS; s++) begin
         mlru[s] = 1'b0;
         for (int w = 0; w < WAYS; w++) mv[w][s] = 1'b0;
      end
   endtask
   task automatic model_reset();
      model_flush();
      mfill = 1'b0;
      mabort = 1'b0;
      mbeats.delete();
      mhit_n = 0;
      mmiss_n = 0;
   endtask
   // One clock cycle: drive, compare against the model, then advance the model past the edge.
   task automatic step(input bit rn, input bit rq, input logic [21:0] ba, input bit fl, input bit fv, input logic [3:0] fd);
      int set, hw, fs;
      logic [17:0] tg;
      logic [31:0] line;
      bit eh;
      @(negedge clk);
      reset = rn;
      bus.req = rq;
      bus.paddr = ba[21:1];
      bus.flush_all = fl;
      bus.fill_valid = fv;
      bus.fill_data = fd;
      #1;
      set = int'(ba[3:2]);
      tg = ba[21:4];
      hw = -1;
      for (int w = 0; w < WAYS; w++) if (mv[w][set] && mt[w][set] == tg) hw = w;
      eh = rq && hw >= 0;
      check("hit", 32'(bus.hit), 32'(eh));
      if (eh) check("rdata", 32'(bus.rdata), ba[1] ? 32'(ml[hw][set][31:16]) : 32'(ml[hw][set][15:0]));
      check("busy", 32'(bus.busy), 32'(mfill));
      check("fill_req", 32'(bus.fill_req), 32'(mfill));
      if (mfill) check("fill_addr", 32'(bus.fill_addr), 32'(mfa));
`ifdef ICACHE_PERF_EN
      check("hit_cnt", 32'(hit_cnt), 32'(mhit_n));
      check("miss_cnt", 32'(miss_cnt), 32'(mmiss_n));
`endif
      @(posedge clk);
      if (!rn) model_reset();
      else begin
         if (eh) begin
            if (mhit_n < 65535) mhit_n++;
            mlru[set] = (hw == 0);
         end
         if (mfill) begin
            if (fv) mbeats.push_back(fd);
            if (fv && mbeats.size() == BEATS) begin
               line = '0;
               for (int i = 0; i < BEATS; i++) line |= 32'(mbeats[i]) << (FW * i);
               fs = int'(mfa[1:0]);
               mt[mvic][fs] = mfa[19:2];
               ml[mvic][fs] = line;
               mv[mvic][fs] = !(mabort || fl);
               mlru[fs] = (mvic == 0);
               mfill = 1'b0;
            end
            if (fl) mabort = 1'b1;
         end else if (rq && !eh && !fl) begin
            mfill = 1'b1;
            mfa = ba[21:2];
            mvic = !mv[0][set] ? 0 : !mv[1][set] ? 1 : int'(mlru[set]);
            mv[mvic][set] = 1'b0;
            mbeats.delete();
            mabort = 1'b0;
            if (mmiss_n < 65535) mmiss_n++;
         end
         if (fl) model_flush();
      end
   endtask
   task automatic fill(input int n, input int base, input bit down);
      for (int i = 1; i <= n; i++) step(1, 0, 0, 0, 1, down ? 4'(base - i) : 4'(base + i));
   endtask
   initial begin
      bus.req = 1'b1;
      bus.paddr = 21'h8;
      bus.flush_all = 1'b0;
      bus.fill_valid = 1'b0;
      bus.fill_data = '0;
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      check("rst_hit", 32'(bus.hit), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_fill_req", 32'(bus.fill_req), 0);
      step(1, 1, 22'h10, 0, 0, 0);
      #1;
      check("t1_fill_req", 32'(bus.fill_req), 1);
      check("t1_busy", 32'(bus.busy), 1);
      check("t1_fill_addr", 32'(bus.fill_addr), 32'h4);
      fill(8, 0, 0);
      #1;
      check("t2_busy", 32'(bus.busy), 0);
      step(1, 1, 22'h10, 0, 0, 0);
      #1;
      check("t2_rdata_lo", 32'(bus.rdata), 32'h4321);
      step(1, 1, 22'h12, 0, 0, 0);
      #1;
      check("t2_rdata_hi", 32'(bus.rdata), 32'h8765);
      step(1, 1, 22'h20, 0, 0, 0);
      fill(8, 8, 0);
      step(1, 1, 22'h20, 0, 0, 0);
      #1;
      check("t3_hit_20", 32'(bus.hit), 1);
      step(1, 1, 22'h10, 0, 0, 0);
      #1;
      check("t3_hit_10", 32'(bus.hit), 1);
      step(1, 1, 22'h30, 0, 0, 0);
      fill(8, 3, 0);
      step(1, 1, 22'h10, 0, 0, 0);
      #1;
      check("t3_keep_10", 32'(bus.hit), 1);
      step(1, 1, 22'h20, 0, 0, 0);
      #1;
      check("t3_evict_20", 32'(bus.hit), 0);
      for (int i = 1; i <= 8; i++) begin
         step(1, 0, 0, i == 3, 1, 4'(i));
         #1;
         check("t4_fill_req", 32'(bus.fill_req), i < 8);
      end
      step(1, 1, 22'h20, 0, 0, 0);
      #1;
      check("t4_miss_20", 32'(bus.hit), 0);
      step(1, 1, 22'h10, 0, 0, 0);
      #1;
      check("t4_miss_10", 32'(bus.hit), 0);
      fill(5, 0, 0);
      step(0, 0, 0, 0, 1, 4'h6);
      #1;
      check("t5_fill_req", 32'(bus.fill_req), 0);
      check("t5_busy", 32'(bus.busy), 0);
      step(1, 0, 0, 0, 1, 4'hF);
      #1;
      check("t5_stray", 32'(bus.busy), 0);
      step(1, 1, 22'h20, 0, 0, 0);
      fill(8, 9, 1);
      step(1, 1, 22'h20, 0, 0, 0);
      #1;
      check("t5_rdata_lo", 32'(bus.rdata), 32'h5678);
      step(1, 1, 22'h22, 0, 0, 0);
      #1;
      check("t5_rdata_hi", 32'(bus.rdata), 32'h1234);
      repeat (3000) begin
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0,
              (22'($urandom_range(0, 3)) << 4) | (22'($urandom_range(0, 3)) << 2) | (22'($urandom_range(0, 1)) << 1),
              $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, 4'($urandom));
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
